lockstep_ctrl: RTL and testbench
================================

// Module: lockstep_ctrl
// PURPOSE
//  Game-step lockstep controller, directly upstream of communicate. On each game-timer tick it latches
//  the local direction, drives communicate's send/dir1 and waits for the peer direction (rcvdir/dir2).
//  Emits one step pulse carrying both directions to the snake logic, so both boards advance in lockstep.
//  Single-player: steps immediately with remote dir NONE. Detects link loss by timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  6_500_000  max clk cycles in WAIT for peer dir before link_lost (100 ms @ 65 MHz)
//  SEND_HOLD       2          cycles send is held high per step (>=1; communicate edge-detects send)
// PORTS
//  clk              in   1  system clock, single clock domain
//  rst_n            in   1  synchronous reset, active low
//  game_en          in   1  level: game running; low = soft reset to IDLE
//  singleplayer     in   1  level: no link partner
//  start_game       in   1  from communicate: peer seed received (sticky, used as link-armed)
//  seed_rdy         in   1  local seed sent pulse (host side arms link)
//  step_req         in   1  1-cycle pulse from game timer
//  local_dir        in   3  direction (snake_pkg) from local input
//  rcvdir           in   1  from communicate: 1-cycle pulse, dir2 valid
//  dir2             in   3  direction: peer direction
//  send             out  1  to communicate: send request
//  dir1             out  3  direction: latched local dir to communicate
//  step             out  1  1-cycle pulse: advance game one step
//  step_dir_local   out  3  direction: valid with step
//  step_dir_remote  out  3  direction: valid with step (NONE in single-player)
//  link_lost        out  1  sticky: peer timeout
//  overrun          out  1  sticky: step_req while busy, or peer FIFO overflow
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; send=0, step=0, link_lost=0, overrun=0; dir1, step_dir_*=NONE;
//   peer FIFO empty, armed=0, timeout counter=0. Same on game_en=0 (any state, takes priority).
//  armed: sticky, set by seed_rdy=1 or start_game=1 while game_en; cleared in IDLE-by-game_en=0.
//  States:
//   IDLE  : -> ARMED when game_en & (singleplayer | armed).
//   ARMED : on step_req: dir1<=local_dir; singleplayer -> STEP, else -> SEND.
//   SEND  : send=1 for SEND_HOLD cycles, then -> WAIT, timeout counter cleared.
//   WAIT  : FIFO non-empty -> STEP; else counter++; counter==TIMEOUT_CYCLES-1 -> LOST.
//   STEP  : step=1 one cycle; step_dir_local=dir1; step_dir_remote=FIFO head (pop) or NONE if singleplayer;
//           -> ARMED. step_dir_* hold value until next step.
//   LOST  : link_lost=1, send=0, no steps; exit only via game_en=0 or reset.
//  Latency: single-player step_req -> step 2 cycles; multiplayer with peer dir already queued:
//   SEND_HOLD+2 cycles; otherwise step 1 cycle after FIFO write.
//  Peer FIFO: 2-entry, written on rcvdir in ARMED/SEND/WAIT/STEP (peer may be up to one step ahead);
//   rcvdir in IDLE/LOST ignored. Write when full: dropped, overrun<=1. Write+pop same cycle (STEP):
//   both occur, occupancy unchanged.
//  step_req outside ARMED: ignored, overrun<=1 (single-player STEP state included).
//  singleplayer sampled only at step_req in ARMED; changes mid-step take effect next step.
//  Timeout counter width $clog2(TIMEOUT_CYCLES+1), saturates never (LOST entered first).
//  send never asserted in single-player; send low for >=1 cycle between consecutive steps.
// STRUCTURE
//  direction type and NONE from snake_pkg; add lockstep_state_t enum (IDLE,ARMED,SEND,WAIT,STEP,LOST)
//  to snake_pkg for debug/ILA visibility. Sub-module dir_fifo2: 2-entry direction FIFO
//  (wr, rd, din, dout, empty, full), sync active-low reset, pop-of-empty ignored.
// TESTING (bench TIMEOUT_CYCLES=20, SEND_HOLD=2)
//  1 singleplayer=1, game_en=1, local_dir=UP, step_req -> step after 2 cycles, local=UP, remote=NONE, send never 1.
//  2 multi, seed_rdy pulse, step_req local=LEFT, rcvdir dir2=RIGHT 3 cycles later -> send high 2 cycles,
//    one step with local=LEFT remote=RIGHT.
//  3 multi, rcvdir dir2=DOWN then rcvdir UP before any step_req -> two step_reqs yield remote DOWN then UP;
//    third early rcvdir while FIFO full -> dropped, overrun=1.
//  4 multi, step_req, no rcvdir -> WAIT exits to LOST after 20 cycles, link_lost=1, no step; game_en=0
//    -> IDLE, link_lost=0.
//  5 step_req during WAIT -> ignored, overrun=1; rst_n=0 mid-SEND -> send=0, all outputs reset values next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding and lockstep controller state (exported for ILA/debug).
package snake_pkg;

    typedef enum logic [2:0] {
        DirNone  = 3'd0,
        DirUp    = 3'd1,
        DirDown  = 3'd2,
        DirLeft  = 3'd3,
        DirRight = 3'd4
    } dir_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StSend  = 3'd2,
        StWait  = 3'd3,
        StStep  = 3'd4,
        StLost  = 3'd5
    } lockstep_state_t;

endpackage

// File: rtl/lockstep_ctrl_if.sv
// Control/handshake bundle between the game host, communicate and the lockstep controller.
interface lockstep_ctrl_if
    import snake_pkg::*;
();
    logic game_en;
    logic singleplayer;
    logic start_game;
    logic seed_rdy;
    logic step_req;
    dir_t local_dir;
    logic rcvdir;
    dir_t dir2;
    logic send;
    dir_t dir1;
    logic step;
    dir_t step_dir_local;
    dir_t step_dir_remote;
    logic link_lost;
    logic overrun;

    // Host / communicate side.
    modport master (
        output game_en, singleplayer, start_game, seed_rdy, step_req, local_dir, rcvdir, dir2,
        input  send, dir1, step, step_dir_local, step_dir_remote, link_lost, overrun
    );

    // Lockstep controller side.
    modport slave (
        input  game_en, singleplayer, start_game, seed_rdy, step_req, local_dir, rcvdir, dir2,
        output send, dir1, step, step_dir_local, step_dir_remote, link_lost, overrun
    );
endinterface

// File: rtl/lockstep_ctrl_dir_fifo2.sv
// Two-entry direction FIFO holding peer directions that arrive ahead of the local step.
module dir_fifo2
    import snake_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic wr_i,
    input  logic rd_i,
    input  dir_t din_i,
    output dir_t dout_o,
    output logic empty_o,
    output logic full_o
);
    dir_t       mem_q [2];
    logic       wptr_q, rptr_q;
    logic [1:0] cnt_q, cnt_d;
    logic       do_wr, do_rd;

    // A write while full is accepted only when a pop frees the slot in the same cycle.
    assign do_rd   = rd_i & (cnt_q != 2'd0);
    assign do_wr   = wr_i & ((cnt_q != 2'd2) | do_rd);
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign dout_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) cnt_d = cnt_q + 2'd1;
        else if (do_rd && !do_wr) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q[0] <= DirNone;
            mem_q[1] <= DirNone;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_wr) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_rd) rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/lockstep_ctrl.sv
// Game-step lockstep controller: exchanges local/peer directions via communicate and issues
// one step pulse per game tick carrying both, with link-loss timeout and overrun flags.
module lockstep_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 6_500_000,
    parameter int unsigned SEND_HOLD      = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    lockstep_ctrl_if.slave bus
);
    localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HoldW = (SEND_HOLD > 1) ? $clog2(SEND_HOLD) : 1;

    lockstep_state_t  state_q;
    logic             send_q, step_q, link_lost_q, overrun_q, armed_q, sp_q;
    dir_t             dir1_q, step_dir_local_q, step_dir_remote_q;
    logic [CntW-1:0]  cnt_q;
    logic [HoldW-1:0] hold_q;

    logic fifo_rst_n, fifo_wr, fifo_rd, fifo_empty, fifo_full, fifo_avail;
    dir_t fifo_dout;

    assign fifo_rst_n = rst_ni & bus.game_en;
    assign fifo_wr    = bus.rcvdir & (state_q inside {StArmed, StSend, StWait, StStep});
    assign fifo_rd    = (state_q == StStep) & ~sp_q;
    // Treat a direction arriving this cycle as already queued so the step is not delayed a cycle.
    assign fifo_avail = ~fifo_empty | fifo_wr;

    dir_fifo2 u_fifo (
        .clk_i  (clk_i),
        .rst_ni (fifo_rst_n),
        .wr_i   (fifo_wr),
        .rd_i   (fifo_rd),
        .din_i  (bus.dir2),
        .dout_o (fifo_dout),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !bus.game_en) begin
            state_q           <= StIdle;
            send_q            <= 1'b0;
            step_q            <= 1'b0;
            link_lost_q       <= 1'b0;
            overrun_q         <= 1'b0;
            armed_q           <= 1'b0;
            sp_q              <= 1'b0;
            dir1_q            <= DirNone;
            step_dir_local_q  <= DirNone;
            step_dir_remote_q <= DirNone;
            cnt_q             <= '0;
            hold_q            <= '0;
        end else begin
            step_q <= 1'b0;
            if (bus.seed_rdy || bus.start_game) armed_q <= 1'b1;
            if ((bus.step_req && state_q != StArmed) || (fifo_wr && fifo_full && !fifo_rd)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.singleplayer || armed_q) state_q <= StArmed;
                end
                StArmed: begin
                    if (bus.step_req) begin
                        dir1_q <= bus.local_dir;
                        sp_q   <= bus.singleplayer;
                        if (bus.singleplayer) begin
                            state_q <= StStep;
                        end else begin
                            send_q  <= 1'b1;
                            hold_q  <= '0;
                            state_q <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (hold_q == HoldW'(SEND_HOLD - 1)) begin
                        send_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= fifo_avail ? StStep : StWait;
                    end else begin
                        hold_q <= hold_q + HoldW'(1);
                    end
                end
                StWait: begin
                    if (fifo_avail) begin
                        state_q <= StStep;
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        link_lost_q <= 1'b1;
                        state_q     <= StLost;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStep: begin
                    step_q            <= 1'b1;
                    step_dir_local_q  <= dir1_q;
                    step_dir_remote_q <= sp_q ? DirNone : fifo_dout;
                    state_q           <= StArmed;
                end
                StLost: state_q <= StLost;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.send            = send_q;
    assign bus.dir1            = dir1_q;
    assign bus.step            = step_q;
    assign bus.step_dir_local  = step_dir_local_q;
    assign bus.step_dir_remote = step_dir_remote_q;
    assign bus.link_lost       = link_lost_q;
    assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_lockstep_ctrl.sv
// Self-checking bench for lockstep_ctrl: directed vector table, corner sequences and random steps.
module tb_lockstep_ctrl;
    import snake_pkg::*;

    localparam int unsigned TO = 20;
    localparam int unsigned SH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lockstep_ctrl_if bus ();

    lockstep_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .SEND_HOLD     (SH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    dir_t peer_q[$];

    typedef struct {
        logic sp;
        dir_t local_d;
        dir_t peer;
        int   d;
        int   exp_lat;
        dir_t exp_remote;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic arm_multi();
        bus.game_en      = 1'b1;
        bus.singleplayer = 1'b0;
        bus.seed_rdy     = 1'b1;
        tick();
        bus.seed_rdy = 1'b0;
        tick();
        tick();
    endtask

    task automatic prequeue(input dir_t p);
        bus.rcvdir = 1'b1;
        bus.dir2   = p;
        tick();
        bus.rcvdir = 1'b0;
    endtask

    // One step transaction: step_req in cycle 0, peer dir in cycle d (d<0: none sent).
    task automatic run_step(input string tag, input logic sp, input dir_t ld, input dir_t peer,
                            input int d, input int exp_lat, input dir_t exp_remote);
        int lat   = -1;
        int sends = 0;
        bus.singleplayer = sp;
        bus.local_dir    = ld;
        bus.dir2         = peer;
        bus.step_req     = 1'b1;
        bus.rcvdir       = (d == 0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            bus.step_req = 1'b0;
            bus.rcvdir   = (d == c);
            sends += int'(bus.send);
            if (bus.step) begin
                lat = c;
                break;
            end
        end
        bus.rcvdir = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " send_cycles"}, sends, sp ? 0 : SH);
        check({tag, " dir1"}, bus.dir1, ld);
        check({tag, " local"}, bus.step_dir_local, ld);
        check({tag, " remote"}, bus.step_dir_remote, exp_remote);
        tick();
        check({tag, " step_one_cycle"}, bus.step, 1'b0);
        check({tag, " remote_held"}, bus.step_dir_remote, exp_remote);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.game_en      = 1'b0;
        bus.singleplayer = 1'b0;
        bus.start_game   = 1'b0;
        bus.seed_rdy     = 1'b0;
        bus.step_req     = 1'b0;
        bus.local_dir    = DirNone;
        bus.rcvdir       = 1'b0;
        bus.dir2         = DirNone;

        vecs[0] = '{1'b0, DirLeft,  DirRight, 3,  5,  DirRight};
        vecs[1] = '{1'b0, DirDown,  DirUp,    0,  4,  DirUp};
        vecs[2] = '{1'b0, DirRight, DirLeft,  2,  4,  DirLeft};
        vecs[3] = '{1'b0, DirUp,    DirDown,  7,  9,  DirDown};
        vecs[4] = '{1'b1, DirLeft,  DirNone,  -1, 2,  DirNone};
        vecs[5] = '{1'b0, DirDown,  DirRight, 21, 23, DirRight};
        vecs[6] = '{1'b1, DirRight, DirNone,  -1, 2,  DirNone};

        // Reset values
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst send", bus.send, 1'b0);
        check("rst step", bus.step, 1'b0);
        check("rst dir1", bus.dir1, DirNone);
        check("rst local", bus.step_dir_local, DirNone);
        check("rst remote", bus.step_dir_remote, DirNone);
        check("rst link_lost", bus.link_lost, 1'b0);
        check("rst overrun", bus.overrun, 1'b0);

        // Single-player step with UP
        bus.game_en      = 1'b1;
        bus.singleplayer = 1'b1;
        tick();
        tick();
        run_step("sp_up", 1'b1, DirUp, DirNone, -1, 2, DirNone);

        // Directed vector table, multiplayer armed via seed_rdy
        arm_multi();
        for (int i = 0; i < 7; i++) begin
            run_step($sformatf("vec%0d", i), vecs[i].sp, vecs[i].local_d, vecs[i].peer, vecs[i].d,
                     vecs[i].exp_lat, vecs[i].exp_remote);
        end

        // Random steps against a queue/latency-rule model
        for (int i = 0; i < 40; i++) begin
            logic sp;
            dir_t ld, p, er;
            int   d, el;
            sp = ($urandom_range(0, 3) == 0);
            ld = dir_t'($urandom_range(1, 4));
            p  = dir_t'($urandom_range(1, 4));
            if (sp) begin
                run_step($sformatf("rnd%0d", i), 1'b1, ld, DirNone, -1, 2, DirNone);
            end else begin
                if (peer_q.size() == 0 && $urandom_range(0, 2) == 0) begin
                    prequeue(p);
                    peer_q.push_back(p);
                end
                if (peer_q.size() != 0) begin
                    d  = -1;
                    el = SH + 2;
                end else begin
                    d = $urandom_range(0, 10);
                    peer_q.push_back(p);
                    el = (d + 2 > SH + 2) ? d + 2 : SH + 2;
                end
                er = peer_q.pop_front();
                run_step($sformatf("rnd%0d", i), 1'b0, ld, p, d, el, er);
            end
        end
        check("rnd overrun", bus.overrun, 1'b0);
        check("rnd link_lost", bus.link_lost, 1'b0);

        // FIFO: two early peer dirs queue in order, a third is dropped with overrun
        bus.singleplayer = 1'b0;
        prequeue(DirDown);
        prequeue(DirUp);
        check("fifo2 no_overrun", bus.overrun, 1'b0);
        prequeue(DirLeft);
        check("fifo full overrun", bus.overrun, 1'b1);
        run_step("fifo_a", 1'b0, DirRight, DirNone, -1, SH + 2, DirDown);
        run_step("fifo_b", 1'b0, DirUp, DirNone, -1, SH + 2, DirUp);
        run_step("fifo_c", 1'b0, DirLeft, DirRight, 5, 7, DirRight);

        // game_en low clears sticky flags
        bus.game_en = 1'b0;
        tick();
        check("soft_rst overrun", bus.overrun, 1'b0);

        // step_req during WAIT -> overrun, the pending step still completes
        arm_multi();
        bus.local_dir = DirUp;
        bus.step_req  = 1'b1;
        tick();
        bus.step_req = 1'b0;
        tick();
        tick();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        check("wait step_req overrun", bus.overrun, 1'b1);
        begin
            bit seen = 1'b0;
            bus.rcvdir = 1'b1;
            bus.dir2   = DirLeft;
            tick();
            bus.rcvdir = 1'b0;
            for (int c = 0; c < 5 && !seen; c++) begin
                if (bus.step) begin
                    seen = 1'b1;
                    check("wait step remote", bus.step_dir_remote, DirLeft);
                end else begin
                    tick();
                end
            end
            check("wait step seen", seen, 1'b1);
        end
        tick();

        // Reset during SEND
        bus.local_dir = DirDown;
        bus.step_req  = 1'b1;
        tick();
        bus.step_req = 1'b0;
        check("send high", bus.send, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst send", bus.send, 1'b0);
        check("midrst step", bus.step, 1'b0);
        check("midrst dir1", bus.dir1, DirNone);
        check("midrst local", bus.step_dir_local, DirNone);
        check("midrst remote", bus.step_dir_remote, DirNone);
        check("midrst overrun", bus.overrun, 1'b0);
        check("midrst link_lost", bus.link_lost, 1'b0);
        rst_n = 1'b1;

        // Peer timeout: 20 WAIT cycles then LOST
        arm_multi();
        begin
            int steps = 0;
            bus.local_dir = DirRight;
            bus.step_req  = 1'b1;
            for (int c = 1; c <= 22; c++) begin
                tick();
                bus.step_req = 1'b0;
                steps += int'(bus.step);
            end
            check("to before link_lost", bus.link_lost, 1'b0);
            tick();
            check("to link_lost", bus.link_lost, 1'b1);
            bus.rcvdir = 1'b1;
            bus.dir2   = DirUp;
            for (int c = 0; c < 4; c++) begin
                tick();
                bus.rcvdir = 1'b0;
                steps += int'(bus.step);
            end
            check("to no_step", steps, 0);
            check("to send low", bus.send, 1'b0);
            check("to sticky", bus.link_lost, 1'b1);
        end
        bus.game_en = 1'b0;
        tick();
        check("to cleared", bus.link_lost, 1'b0);

        // armed cleared by game_en low: no send, step_req flagged as overrun
        bus.game_en      = 1'b1;
        bus.singleplayer = 1'b0;
        tick();
        tick();
        tick();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        tick();
        check("unarmed send", bus.send, 1'b0);
        check("unarmed overrun", bus.overrun, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
